glitch_pulse_gen: RTL and testbench

Trigger-driven glitch pulse generator on the consumer side of the UART configuration path. It takes the delay, width, pulse count, spacing and enable values produced by the UART command handler and waits for a target trigger. It then emits the programmed burst of glitch pulses on `pulse_o`. It sits between the UART handler outputs and the glitch output pin in the glitch controller top level.

---
 rtl/glitch_pulse_gen.sv | 161 ++++++++++++++++
 tb/tb_glitch_pulse_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_pulse_gen.sv
// Trigger-driven glitch burst generator: arms on en_i, waits for a synchronized
// trigger rising edge, then emits a delayed burst of N pulses of width W and spacing S.
module glitch_pulse_gen #(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger_i,
    input  logic [15:0] delay_i,
    input  logic [7:0]  width_i,
    input  logic [7:0]  num_pulses_i,
    input  logic [15:0] spacing_i,
    input  logic        en_i,
    output logic        pulse_o,
    output logic        armed_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_prev_q;
    logic                   trig_rise;

    logic [15:0] cnt_q, cnt_d;          // shared delay / gap down-counter
    logic [7:0]  wcnt_q, wcnt_d;        // pulse-width down-counter
    logic [7:0]  pcnt_q, pcnt_d;        // pulses still to emit
    logic [7:0]  width_q, width_d;
    logic [15:0] spacing_q, spacing_d;
    logic        pulse_q, pulse_d;
    logic        done_q, done_d;

    logic [7:0]  w_load;
    logic [15:0] s_load;

    // Zero width or spacing is promoted to one cycle; counters load (value-1).
    assign w_load = (width_q == 8'd0) ? 8'd0 : width_q - 8'd1;
    assign s_load = (spacing_q == 16'd0) ? 16'd0 : spacing_q - 16'd1;

    // A trigger that is already high when arming never looks like a fresh edge.
    assign trig_rise = sync_q[SYNC_STAGES-1] & ~trig_prev_q;

    // NOTE: every variable is given a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        pcnt_d    = pcnt_q;
        width_d   = width_q;
        spacing_d = spacing_q;
        pulse_d   = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (trig_rise) begin
                    width_d   = width_i;
                    spacing_d = spacing_i;
                    pcnt_d    = num_pulses_i;
                    cnt_d     = delay_i;
                    if (num_pulses_i == 8'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_PULSE;
                    pulse_d = 1'b1;
                    wcnt_d  = w_load;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PULSE: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 8'd0) begin
                    pcnt_d = pcnt_q - 8'd1;
                    if (pcnt_q == 8'd1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = s_load;
                    end
                end else begin
                    wcnt_d  = wcnt_q - 8'd1;
                    pulse_d = 1'b1;
                end
            end
            S_GAP: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_PULSE;
                    pulse_d = 1'b1;
                    wcnt_d  = w_load;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                if (!en_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            pcnt_q      <= '0;
            width_q     <= '0;
            spacing_q   <= '0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], trigger_i};
            trig_prev_q <= sync_q[SYNC_STAGES-1];
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            pcnt_q      <= pcnt_d;
            width_q     <= width_d;
            spacing_q   <= spacing_d;
            pulse_q     <= pulse_d;
            done_q      <= done_d;
        end
    end

    assign pulse_o = pulse_q;
    assign done_o  = done_q;
    assign armed_o = (state_q == S_ARMED);
    assign busy_o  = (state_q == S_DELAY) || (state_q == S_PULSE) || (state_q == S_GAP);

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen: table of burst configurations plus hand
// sequences for abort, ignored triggers, config changes and async reset.
module tb_glitch_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger_i;
    logic [15:0] delay_i;
    logic [7:0]  width_i;
    logic [7:0]  num_pulses_i;
    logic [15:0] spacing_i;
    logic        en_i;
    logic        pulse_o, armed_o, busy_o, done_o;

    int total = 0;
    int bad   = 0;

    glitch_pulse_gen #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .trigger_i    (trigger_i),
        .delay_i      (delay_i),
        .width_i      (width_i),
        .num_pulses_i (num_pulses_i),
        .spacing_i    (spacing_i),
        .en_i         (en_i),
        .pulse_o      (pulse_o),
        .armed_o      (armed_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Timings are cycle indices counted from the first falling edge after the
    // ARMED->DELAY transition (index 0).
    typedef struct {
        logic [15:0] d;
        logic [7:0]  w;
        logic [7:0]  n;
        logic [15:0] s;
        int first;
        int wid;
        int per;
        int np;
        int done_at;
        int busy;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic arm_and_fire(input logic [15:0] d, input logic [7:0] w,
                                input logic [7:0] n, input logic [15:0] s);
        int i;
        trigger_i = 1'b0;
        en_i      = 1'b0;
        repeat (4) @(negedge clk);
        delay_i = d; width_i = w; num_pulses_i = n; spacing_i = s;
        en_i = 1'b1;
        repeat (2) @(negedge clk);
        check("armed_before_trigger", int'(armed_o), 1);
        trigger_i = 1'b1;
        for (i = 0; i < 8 && armed_o; i++) @(negedge clk);
        check("trigger_detected", int'(armed_o), 0);
    endtask

    task automatic capture(input int len, output int first, output int minw, output int maxw,
                           output int minper, output int maxper, output int np,
                           output int done_at, output int done_cnt, output int busy_cnt);
        logic prev = 1'b0;
        int last_rise = -1;
        first = -1; minw = 1000; maxw = 0; minper = 1000; maxper = 0;
        np = 0; done_at = -1; done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < len; k++) begin
            if (pulse_o && !prev) begin
                if (np == 0) first = k;
                else begin
                    if (k - last_rise < minper) minper = k - last_rise;
                    if (k - last_rise > maxper) maxper = k - last_rise;
                end
                np++;
                last_rise = k;
            end
            if (!pulse_o && prev) begin
                if (k - last_rise < minw) minw = k - last_rise;
                if (k - last_rise > maxw) maxw = k - last_rise;
            end
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (busy_o) busy_cnt++;
            prev = pulse_o;
            @(negedge clk);
        end
        if (np == 0) begin minw = 0; maxw = 0; end
        if (np < 2)  begin minper = 0; maxper = 0; end
    endtask

    task automatic run_vec(input vec_t v);
        int first, minw, maxw, minper, maxper, np, done_at, done_cnt, busy_cnt;
        arm_and_fire(v.d, v.w, v.n, v.s);
        capture(40, first, minw, maxw, minper, maxper, np, done_at, done_cnt, busy_cnt);
        check("first_rise", first, v.first);
        check("min_width", minw, v.wid);
        check("max_width", maxw, v.wid);
        check("min_period", minper, v.per);
        check("max_period", maxper, v.per);
        check("pulse_count", np, v.np);
        check("done_at", done_at, v.done_at);
        check("done_count", done_cnt, 1);
        check("busy_cycles", busy_cnt, v.busy);
        en_i = 1'b0;
        @(negedge clk);
        check("idle_after_burst", int'({armed_o, busy_o, pulse_o, done_o}), 0);
    endtask

    initial begin
        int rises, highs, dones, lowarm, lat, i;

        vecs[0] = '{16'd10, 8'd5, 8'd1, 16'd0, 11, 5, 0, 1, 16, 16};
        vecs[1] = '{16'd0,  8'd2, 8'd3, 16'd4, 1,  2, 6, 3, 15, 15};
        vecs[2] = '{16'd3,  8'd0, 8'd2, 16'd0, 4,  1, 2, 2, 7,  7};
        vecs[3] = '{16'd5,  8'd7, 8'd0, 16'd3, -1, 0, 0, 0, 0,  0};
        vecs[4] = '{16'd2,  8'd3, 8'd2, 16'd1, 3,  3, 4, 2, 10, 10};
        vecs[5] = '{16'd1,  8'd4, 8'd4, 16'd2, 2,  4, 6, 4, 24, 24};

        rst = 1'b0; trigger_i = 1'b0; en_i = 1'b0;
        delay_i = '0; width_i = '0; num_pulses_i = '0; spacing_i = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({pulse_o, armed_o, busy_o, done_o}), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", int'({pulse_o, armed_o, busy_o, done_o}), 0);

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Abort during the second of four pulses, then a full burst after re-arm.
        arm_and_fire(16'd1, 8'd4, 8'd4, 16'd2);
        rises = 0;
        for (i = 0; i < 20 && rises < 2; i++) begin
            @(negedge clk);
            if (pulse_o) begin
                rises++;
                if (rises < 2) while (pulse_o) @(negedge clk);
            end
        end
        check("abort_reached_second_pulse", rises, 2);
        en_i = 1'b0;
        @(negedge clk);
        check("abort_pulse_low", int'(pulse_o), 0);
        check("abort_state_idle", int'({armed_o, busy_o}), 0);
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            dones += int'(done_o);
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        run_vec(vecs[5]);

        // Extra trigger edges and config changes during DELAY are ignored.
        arm_and_fire(16'd20, 8'd2, 8'd1, 16'd0);
        rises = 0; highs = 0; dones = 0; lat = -1;
        for (int k = 0; k < 30; k++) begin
            if (pulse_o) begin
                highs++;
                if (lat < 0) lat = k;
            end
            dones += int'(done_o);
            if (k >= 3 && k <= 9) trigger_i = (k % 2 == 1);
            if (k == 5) begin
                delay_i = 16'd0; width_i = 8'd9; num_pulses_i = 8'd5; spacing_i = 16'd1;
            end
            @(negedge clk);
        end
        check("ignore_first_rise", lat, 21);
        check("ignore_high_cycles", highs, 2);
        check("ignore_done_count", dones, 1);

        // Trigger held high across DONE and re-arm must not start a burst.
        en_i = 1'b0;
        repeat (2) @(negedge clk);
        en_i = 1'b1;
        @(negedge clk);
        lowarm = 0;
        for (int k = 0; k < 10; k++) begin
            lowarm += int'(!armed_o || busy_o);
            @(negedge clk);
        end
        check("held_trigger_no_burst", lowarm, 0);
        trigger_i = 1'b0;
        repeat (4) @(negedge clk);
        trigger_i = 1'b1;
        lat = 0;
        for (i = 0; i < 8 && armed_o; i++) begin
            @(negedge clk);
            lat++;
        end
        check("fresh_edge_latency", lat, 3);
        en_i = 1'b0;
        trigger_i = 1'b0;
        @(negedge clk);

        // Asynchronous reset while the pulse is high.
        arm_and_fire(16'd0, 8'd10, 8'd1, 16'd0);
        for (i = 0; i < 10 && !pulse_o; i++) @(negedge clk);
        check("reset_test_pulse_high", int'(pulse_o), 1);
        #2 rst = 1'b0;
        #1 check("async_reset_drops_pulse", int'(pulse_o), 0);
        check("async_reset_state", int'({armed_o, busy_o, done_o}), 0);
        en_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("after_reset_outputs", int'({pulse_o, armed_o, busy_o, done_o}), 0);
        en_i = 1'b1;
        @(negedge clk);
        check("rearm_from_idle", int'(armed_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
